// File: rtl/c5_negate_pkg.sv
// Shared encodings for the c5_negate_seq digit-serial negate/abs/complement unit.
package c5_negate_pkg;

    typedef enum logic [1:0] {
        ModePass = 2'b00,
        ModeNeg  = 2'b01,
        ModeAbs  = 2'b10,
        ModeNot  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // Returns {inv, carry_in} for the first digit of an operation.
    function automatic logic [1:0] mode_ctl(input mode_e mode, input logic sign);
        logic [1:0] ctl;
        ctl = 2'b00;
        case (mode)
            ModePass: ctl = 2'b00;
            ModeNeg:  ctl = 2'b11;
            ModeAbs:  ctl = {sign, sign};
            ModeNot:  ctl = 2'b10;
            default:  ctl = 2'b00;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/c5_negate_digit.sv
// One DIGIT-wide slice: optional bitwise invert followed by a carry-in increment.
module c5_negate_digit #(
    parameter int unsigned DIGIT = 8
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic             i_inv,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout
);

    logic [DIGIT-1:0] w_op;

    assign w_op            = i_inv ? ~i_a : i_a;
    assign {o_cout, o_sum} = {1'b0, w_op} + {{DIGIT{1'b0}}, i_cin};

endmodule

// File: rtl/c5_negate_seq.sv
// Digit-serial pass/negate/abs/ones-complement, LSB digit first, one digit per cycle.
// Optional overflow flag O_ovf is built only when C5_NEGATE_OVF_EN is defined.
module c5_negate_seq
    import c5_negate_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 8
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_valid,
    output logic             O_ready,
    input  logic [1:0]       I_mode,
    input  logic [WIDTH-1:0] I_a,
    output logic             O_valid,
    input  logic             I_ready,
`ifdef C5_NEGATE_OVF_EN
    output logic             O_ovf,
`endif
    output logic [WIDTH-1:0] O_result
);

    localparam int unsigned NumDig = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
    localparam int unsigned CntW   = (NumDig > 1) ? $clog2(NumDig) : 1;
    localparam int unsigned IdxW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH == 0 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("c5_negate_seq: WIDTH must be a nonzero multiple of DIGIT");
    end

    state_e            r_state;
    state_e            w_state_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_result;
    logic [CntW-1:0]   r_cnt;
    logic              r_inv;
    logic              r_carry;
    logic              w_accept;
    logic              w_last;
    logic [1:0]        w_ctl;
    logic [IdxW-1:0]   w_base;
    logic [DIGIT-1:0]  w_a_dig;
    logic [DIGIT-1:0]  w_sum;
    logic              w_cout;

    assign w_accept = I_valid && (r_state == StIdle);
    assign w_last   = (r_cnt == CntW'(NumDig - 1));
    assign w_ctl    = mode_ctl(mode_e'(I_mode), I_a[WIDTH-1]);
    assign w_base   = IdxW'(32'(r_cnt) * DIGIT);
    assign w_a_dig  = r_a[w_base +: DIGIT];

    c5_negate_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .i_a    (w_a_dig),
        .i_inv  (r_inv),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_accept) w_state_next = StRun;
            StRun:  if (w_last)   w_state_next = StDone;
            StDone: if (I_ready)  w_state_next = StIdle;
            default:              w_state_next = StIdle;
        endcase
    end

`ifdef C5_NEGATE_OVF_EN
    logic r_ovf;

    // Only the most negative value has no positive two's-complement counterpart.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= ((mode_e'(I_mode) == ModeNeg) || (mode_e'(I_mode) == ModeAbs)) &&
                     (I_a == {1'b1, {(WIDTH-1){1'b0}}});
        end
    end
`endif

    always_comb begin
        O_ready  = (r_state == StIdle);
        O_valid  = (r_state == StDone);
        O_result = r_result;
`ifdef C5_NEGATE_OVF_EN
        O_ovf    = (r_state == StDone) && r_ovf;
`endif
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_a      <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_inv    <= 1'b0;
            r_carry  <= 1'b0;
        end else if (w_accept) begin
            r_a      <= I_a;
            r_result <= '0;
            r_cnt    <= '0;
            r_inv    <= w_ctl[1];
            r_carry  <= w_ctl[0];
        end else if (r_state == StRun) begin
            r_result[w_base +: DIGIT] <= w_sum;
            r_carry                   <= w_cout;
            r_cnt                     <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_c5_negate_seq.sv
// Directed bench for c5_negate_seq at DIGIT=8, 32 and 1 (WIDTH=32 throughout).
module tb_c5_negate_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v    [3];
    logic        rin  [3];
    logic [1:0]  md   [3];
    logic [31:0] a    [3];
    logic        ordy [3];
    logic        oval [3];
    logic [31:0] ores [3];
`ifdef C5_NEGATE_OVF_EN
    logic        oovf [3];
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    c5_negate_seq #(.WIDTH(32), .DIGIT(8)) u_dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_valid(v[0]), .O_ready(ordy[0]), .I_mode(md[0]),
        .I_a(a[0]), .O_valid(oval[0]), .I_ready(rin[0]),
`ifdef C5_NEGATE_OVF_EN
        .O_ovf(oovf[0]),
`endif
        .O_result(ores[0])
    );

    c5_negate_seq #(.WIDTH(32), .DIGIT(32)) u_d32 (
        .I_clk(clk), .I_rst_n(rst_n), .I_valid(v[1]), .O_ready(ordy[1]), .I_mode(md[1]),
        .I_a(a[1]), .O_valid(oval[1]), .I_ready(rin[1]),
`ifdef C5_NEGATE_OVF_EN
        .O_ovf(oovf[1]),
`endif
        .O_result(ores[1])
    );

    c5_negate_seq #(.WIDTH(32), .DIGIT(1)) u_d1 (
        .I_clk(clk), .I_rst_n(rst_n), .I_valid(v[2]), .O_ready(ordy[2]), .I_mode(md[2]),
        .I_a(a[2]), .O_valid(oval[2]), .I_ready(rin[2]),
`ifdef C5_NEGATE_OVF_EN
        .O_ovf(oovf[2]),
`endif
        .O_result(ores[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // One request on instance d; hold = cycles of I_ready=0 after O_valid rises.
    task automatic op(input int d, input logic [1:0] m, input logic [31:0] opa,
                      input logic [31:0] exp_res, input logic exp_ovf, input int exp_lat,
                      input int hold, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, " ready_before"}, 32'(ordy[d]), 32'd1);
        v[d]  = 1'b1;
        md[d] = m;
        a[d]  = opa;
        @(posedge clk);
        @(negedge clk);
        v[d]  = 1'b0;
        a[d]  = ~opa;
        md[d] = ~m;
        lat   = 0;
        while (oval[d] !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, ores[d], exp_res);
`ifdef C5_NEGATE_OVF_EN
        chk({tag, " ovf"}, 32'(oovf[d]), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("unexpected x");
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, " hold_valid"}, 32'(oval[d]), 32'd1);
            chk({tag, " hold_result"}, ores[d], exp_res);
            chk({tag, " hold_ready"}, 32'(ordy[d]), 32'd0);
        end
        rin[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rin[d] = 1'b0;
        chk({tag, " idle_valid"}, 32'(oval[d]), 32'd0);
        chk({tag, " idle_ready"}, 32'(ordy[d]), 32'd1);
        chk({tag, " idle_result"}, ores[d], exp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v[i]   = 1'b0;
            rin[i] = 1'b0;
            md[i]  = 2'b00;
            a[i]   = 32'h0;
        end
        #12;
        chk("reset ready", 32'(ordy[0]), 32'd1);
        chk("reset valid", 32'(oval[0]), 32'd0);
        chk("reset result", ores[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        op(0, 2'b01, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 4, 0, "neg1");
        op(0, 2'b01, 32'h0000_0000, 32'h0000_0000, 1'b0, 4, 0, "neg0");
        op(0, 2'b10, 32'h8000_0000, 32'h8000_0000, 1'b1, 4, 0, "absmin");
        op(0, 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1, 4, 0, "negmin");
        op(0, 2'b10, 32'hFFFF_FF85, 32'h0000_007B, 1'b0, 4, 0, "absneg");
        op(0, 2'b10, 32'h0000_007B, 32'h0000_007B, 1'b0, 4, 0, "abspos");
        op(0, 2'b11, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 4, 0, "not");
        op(0, 2'b00, 32'h1234_5678, 32'h1234_5678, 1'b0, 4, 0, "pass");
        op(0, 2'b01, 32'h0000_0100, 32'hFFFF_FF00, 1'b0, 4, 5, "backpressure");

        // Abort mid-operation: -0x12345678 = 0xEDCBA988, two digits done -> 0x0000A988.
        @(negedge clk);
        v[0]  = 1'b1;
        md[0] = 2'b01;
        a[0]  = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("abort partial", ores[0], 32'h0000_A988);
        rst_n = 1'b0;
        #1;
        chk("abort valid", 32'(oval[0]), 32'd0);
        chk("abort ready", 32'(ordy[0]), 32'd1);
        chk("abort result", ores[0], 32'h0);
`ifdef C5_NEGATE_OVF_EN
        chk("abort ovf", 32'(oovf[0]), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        op(0, 2'b01, 32'h0000_0002, 32'hFFFF_FFFE, 1'b0, 4, 0, "after_reset");

        op(1, 2'b01, 32'h0000_0003, 32'hFFFF_FFFD, 1'b0, 1, 0, "d32_neg3");
        op(2, 2'b01, 32'h0000_0003, 32'hFFFF_FFFD, 1'b0, 32, 0, "d1_neg3");
        op(2, 2'b10, 32'h8000_0000, 32'h8000_0000, 1'b1, 32, 0, "d1_absmin");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/c5_negate_seq.md
C5_NEGATE_SEQ -- requirements
Module: c5_negate_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 8, bits processed per cycle; WIDTH is a nonzero multiple of DIGIT, else elaboration error.
REQ-003 SHALL have port I_clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port I_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port I_valid  input  1  request valid.
REQ-006 SHALL have port O_ready  output  1  block can accept a request.
REQ-007 SHALL have port I_mode  input  2  operation: 00 pass, 01 negate, 10 abs, 11 ones-complement.
REQ-008 SHALL have port I_a  input  WIDTH  operand, two's complement.
REQ-009 SHALL have port O_valid  output  1  result valid.
REQ-010 SHALL have port I_ready  input  1  consumer accepts result.
REQ-011 SHALL have port O_result  output  WIDTH  result.
REQ-012 SHALL have port O_ovf  output  1  overflow flag (present only with C5_NEGATE_OVF_EN).

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; O_ready=1 only in IDLE, O_valid=1 only in DONE.
REQ-014 SHALL accept a request on a rising edge with I_valid&O_ready, latching I_a, I_mode and clearing digit counter and O_result; go to RUN.
REQ-015 SHALL ignore I_a/I_mode/I_valid changes while in RUN or DONE.
REQ-016 SHALL in RUN process digit k (LSB first, k=0..N-1, N=WIDTH/DIGIT) per cycle: result digit = (inv ? ~a_k : a_k) + carry, carry-out registered for next digit.
REQ-017 SHALL set inv and initial carry per mode: pass inv=0,c=0; negate inv=1,c=1; abs inv=c=latched a[WIDTH-1]; ones-complement inv=1,c=0.
REQ-018 SHALL enter DONE on the edge completing digit N-1; O_valid rises exactly N cycles after the accept edge (N=1 when DIGIT=WIDTH).
REQ-019 SHALL hold O_result and O_valid stable in DONE until I_valid... until I_ready=1, then return to IDLE on that edge; next accept possible the following edge.
REQ-020 SHALL discard final carry-out; negate of 0 yields 0; negate/abs of 2^(WIDTH-1) yields 2^(WIDTH-1).
REQ-021 SHALL keep O_result at its last value in IDLE.

Reset
REQ-022 SHALL on I_rst_n=0, immediately and regardless of state: state IDLE, O_ready=1, O_valid=0, O_result=0, O_ovf=0, counter/carry=0.
REQ-023 SHALL abort any in-flight operation on reset with no output produced; first accept possible on first edge after release.

Configuration
REQ-024 SHALL use macro C5_NEGATE_OVF_EN: when defined, O_ovf exists and is 1 in DONE iff mode is negate or abs and latched operand equals 2^(WIDTH-1), else 0; held with O_result.
REQ-025 SHALL, when C5_NEGATE_OVF_EN is undefined, omit O_ovf port and its logic; all other behaviour identical.

Structure
REQ-026 SHALL place mode encodings (PASS/NEG/ABS/NOT) and FSM state encodings in shared package c5_negate_pkg.
REQ-027 SHALL instantiate combinational sub-module c5_negate_digit (DIGIT-wide conditional invert + carry-in add, carry-out), one instance reused per cycle.

Verification (WIDTH=32, DIGIT=8 unless noted)
REQ-028 SHALL test negate 0x00000001 -> O_result 0xFFFFFFFF, O_valid high exactly 4 cycles after accept, O_ovf=0.
REQ-029 SHALL test negate 0x00000000 -> 0x00000000 (carry across all digits), O_ovf=0; abs 0x80000000 -> 0x80000000, O_ovf=1.
REQ-030 SHALL test abs 0xFFFFFF85 -> 0x0000007B; abs 0x0000007B -> 0x0000007B; ones-complement 0x0F0F0F0F -> 0xF0F0F0F0; pass 0x12345678 -> 0x12345678.
REQ-031 SHALL test backpressure: I_ready=0 for 5 cycles in DONE -> O_result/O_valid stable, O_ready=0; I_ready=1 -> IDLE next edge; I_a changed during RUN has no effect.
REQ-032 SHALL test reset asserted in RUN after 2 digits -> O_valid=0, O_ready=1, O_result=0 immediately; next request negate 0x00000002 -> 0xFFFFFFFE.
REQ-033 SHALL test DIGIT=32 and DIGIT=1 builds: negate 0x00000003 -> 0xFFFFFFFD with latency 1 and 32 cycles respectively.
